// File: rtl/ps2_host_tx_pkg.sv
// PS/2 host transmitter shared definitions.
// FSM states, error codes, well-known command bytes and parity helper.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_IDLE
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NACK    = 2'b10;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake and status bundle of the PS/2 host transmitter.
// The master offers bytes, the slave (transmitter) reports progress.
interface ps2_host_tx_if;

    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       busy;
    logic       tx_done;
    logic       tx_err;
    logic [1:0] err_code;

    modport master (
        output tx_valid, tx_data,
        input  tx_ready, busy, tx_done, tx_err, err_code
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ready, busy, tx_done, tx_err, err_code
    );

endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser plus falling-edge detector for one PS/2 line.
// Reset value is 1 so an idle (pulled-up) line never shows a false edge.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic fe_o
);

    logic s1_q;
    logic s2_q;
    logic prev_q;

    // Resynchronise the pin and keep one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            s1_q   <= line_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign level_o = s2_q;
    assign fe_o    = prev_q & ~s2_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame,
// device ACK check and a watchdog on the device-generated clock.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int RTS_CYCLES     = 10,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic          clk,
    input  logic          rst,
    ps2_host_tx_if.slave  bus,
    input  logic          ps2_clk_i,
    input  logic          ps2_data_i,
    output logic          clk_drv_low,
    output logic          data_drv_low
);

    localparam int TMAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int WW   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [TW-1:0] INH_LOAD = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] RTS_LOAD = TW'(RTS_CYCLES - 1);
    localparam logic [WW-1:0] WD_LOAD  = WW'(TIMEOUT_CYCLES - 1);

    state_e        state_q, state_d;
    logic [8:0]    shreg_q, shreg_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          clk_drv_q, clk_drv_d;
    logic          data_drv_q, data_drv_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          nack_q, nack_d;

    logic clk_lvl, clk_fe;
    logic data_lvl, data_fe;

    ps2_line_sync u_clk_sync (
        .clk     (clk),
        .rst     (rst),
        .line_i  (ps2_clk_i),
        .level_o (clk_lvl),
        .fe_o    (clk_fe)
    );

    ps2_line_sync u_data_sync (
        .clk     (clk),
        .rst     (rst),
        .line_i  (ps2_data_i),
        .level_o (data_lvl),
        .fe_o    (data_fe)
    );

    // State, datapath and registered outputs; reset releases both lines.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            timer_q    <= '0;
            wdog_q     <= '0;
            clk_drv_q  <= 1'b0;
            data_drv_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            nack_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            wdog_q     <= wdog_d;
            clk_drv_q  <= clk_drv_d;
            data_drv_q <= data_drv_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            nack_q     <= nack_d;
        end
    end

    // Transfer sequencing; bits only change on a device falling edge.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        timer_d    = timer_q;
        wdog_d     = wdog_q;
        clk_drv_d  = clk_drv_q;
        data_drv_d = data_drv_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        nack_d     = nack_q;

        unique case (state_q)
            IDLE: begin
                if (bus.tx_valid) begin
                    state_d    = INHIBIT;
                    shreg_d    = {odd_parity(bus.tx_data), bus.tx_data};
                    cnt_d      = '0;
                    timer_d    = INH_LOAD;
                    clk_drv_d  = 1'b1;
                    data_drv_d = 1'b0;
                    err_code_d = ERR_NONE;
                    nack_d     = 1'b0;
                end
            end
            INHIBIT: begin
                if (timer_q == '0) begin
                    state_d    = RTS;
                    timer_d    = RTS_LOAD;
                    data_drv_d = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            RTS: begin
                if (timer_q == '0) begin
                    state_d   = SEND;
                    clk_drv_d = 1'b0;
                    wdog_d    = WD_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            SEND: begin
                if (clk_fe) begin
                    // Shift in ones so the tenth edge drives the stop bit (released).
                    data_drv_d = ~shreg_q[0];
                    shreg_d    = {1'b1, shreg_q[8:1]};
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == 4'd9) begin
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                if (clk_fe) begin
                    nack_d  = data_lvl;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_lvl && data_lvl) begin
                    state_d = IDLE;
                    if (nack_q) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_NACK;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Watchdog only runs while the device owns the clock.
        if (state_q == SEND || state_q == ACK || state_q == WAIT_IDLE) begin
            if (clk_fe) begin
                wdog_d = WD_LOAD;
            end else if (wdog_q == '0) begin
                state_d    = IDLE;
                clk_drv_d  = 1'b0;
                data_drv_d = 1'b0;
                done_d     = 1'b0;
                err_d      = 1'b1;
                err_code_d = ERR_TIMEOUT;
            end else begin
                wdog_d = wdog_q - 1'b1;
            end
        end
    end

    assign bus.tx_ready = (state_q == IDLE);
    assign bus.busy     = (state_q != IDLE);
    assign bus.tx_done  = done_q;
    assign bus.tx_err   = err_q;
    assign bus.err_code = err_code_q;
    assign clk_drv_low  = clk_drv_q;
    assign data_drv_low = data_drv_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: PS/2 device model on a wired-AND bus,
// frame reference computed from the byte, random and directed commands.
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    localparam int INH  = 200;
    localparam int RTSC = 10;
    localparam int TO   = 3000;
    localparam int H    = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic clk_drv_low;
    logic data_drv_low;
    wire  ps2_clk;
    wire  ps2_data;

    int n_chk = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int acc_cnt = 0;
    int exp_done = 0;
    int exp_err = 0;

    ps2_host_tx_if bus ();

    assign ps2_clk  = dev_clk & ~clk_drv_low;
    assign ps2_data = dev_data & ~data_drv_low;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .RTS_CYCLES     (RTSC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .ps2_clk_i    (ps2_clk),
        .ps2_data_i   (ps2_data),
        .clk_drv_low  (clk_drv_low),
        .data_drv_low (data_drv_low)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.tx_done) done_cnt++;
        if (bus.tx_err) err_cnt++;
    end

    always @(posedge clk) begin
        if (rst && bus.tx_valid && bus.tx_ready) acc_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected line levels at the device's sample points: start, d0..d7, parity, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        int ones = 0;
        logic [10:0] f;
        for (int i = 0; i < 8; i++) ones += int'((b >> i) & 8'd1);
        f = '0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic wait_release();
        int cl = 0;
        int dl = 0;
        int n = 0;
        while (n < 2 * (INH + RTSC) + 50) begin
            @(negedge clk);
            n++;
            if (clk_drv_low) begin
                cl++;
                if (data_drv_low) dl++;
            end else if (cl > 0) begin
                break;
            end
        end
        chk("clk_low_len", cl, INH + RTSC);
        chk("data_lead", dl, RTSC);
    endtask

    task automatic dev_frame(input bit ack, output logic [10:0] fr);
        repeat (H) @(negedge clk);
        fr[0] = ps2_data;
        for (int k = 1; k <= 10; k++) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
            fr[k] = ps2_data;
            repeat (H) @(negedge clk);
        end
        dev_data = ack ? 1'b0 : 1'b1;
        repeat (H / 2) @(negedge clk);
        dev_clk = 1'b0;
        repeat (H) @(negedge clk);
        chk("host_released", data_drv_low, 1'b0);
        dev_data = 1'b1;
        dev_clk  = 1'b1;
    endtask

    task automatic wait_pulse();
        int n = 0;
        while (!(bus.tx_done || bus.tx_err) && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    // hold: 0 = one-shot valid, 1 = valid held by caller, 2 = drop it once accepted
    task automatic xfer(input logic [7:0] b, input bit ack, input int hold);
        logic [10:0] fr;
        if (hold == 0) begin
            @(negedge clk);
            bus.tx_valid = 1'b1;
            bus.tx_data  = b;
            @(posedge clk);
            #1 bus.tx_valid = 1'b0;
        end
        wait_release();
        if (hold == 2) bus.tx_valid = 1'b0;
        chk("busy", bus.busy, 1'b1);
        chk("ready_low", bus.tx_ready, 1'b0);
        chk("code_clr", bus.err_code, ERR_NONE);
        dev_frame(ack, fr);
        chk($sformatf("frame_%02h", b), fr, frame_of(b));
        wait_pulse();
        chk("done", bus.tx_done, ack);
        chk("err", bus.tx_err, !ack);
        if (!ack) chk("nack_code", bus.err_code, ERR_NACK);
        chk("busy_after", bus.busy, 1'b0);
        if (ack) exp_done++;
        else exp_err++;
    endtask

    initial begin
        int n;
        int d0;
        int e0;
        int a0;
        logic [7:0] rb;
        bit rack;

        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.tx_ready, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.tx_done, 1'b0);
        chk("rst_err", bus.tx_err, 1'b0);
        chk("rst_code", bus.err_code, ERR_NONE);
        chk("rst_clkdrv", clk_drv_low, 1'b0);
        chk("rst_datadrv", data_drv_low, 1'b0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        xfer(CMD_SET_LED, 1'b1, 0);
        xfer(CMD_ENABLE, 1'b1, 0);
        xfer(8'h5A, 1'b0, 0);
        repeat (10) @(negedge clk);
        chk("code_hold", bus.err_code, ERR_NACK);

        // Device silent after release: watchdog must fire.
        @(negedge clk);
        bus.tx_valid = 1'b1;
        bus.tx_data  = CMD_ENABLE;
        @(posedge clk);
        #1 bus.tx_valid = 1'b0;
        wait_release();
        n = 0;
        while (!bus.tx_err && n < TO + 100) begin
            @(negedge clk);
            n++;
        end
        chk("to_latency", n, TO);
        chk("to_code", bus.err_code, ERR_TIMEOUT);
        chk("to_clkdrv", clk_drv_low, 1'b0);
        chk("to_datadrv", data_drv_low, 1'b0);
        chk("to_nodone", bus.tx_done, 1'b0);
        exp_err++;
        repeat (5) @(negedge clk);

        // Reset in the middle of the data bits.
        @(negedge clk);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h00;
        @(posedge clk);
        #1 bus.tx_valid = 1'b0;
        wait_release();
        repeat (H) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
            repeat (H) @(negedge clk);
        end
        dev_clk = 1'b0;
        repeat (H / 2) @(negedge clk);
        chk("pre_rst_datadrv", data_drv_low, 1'b1);
        d0 = done_cnt;
        e0 = err_cnt;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_clkdrv", clk_drv_low, 1'b0);
        chk("abort_datadrv", data_drv_low, 1'b0);
        chk("abort_ready", bus.tx_ready, 1'b1);
        rst = 1'b1;
        dev_clk = 1'b1;
        repeat (50) @(negedge clk);
        chk("abort_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
        xfer(CMD_RESET, 1'b1, 0);

        // Valid held high: one acceptance per transfer, back to back.
        a0 = acc_cnt;
        @(negedge clk);
        bus.tx_data  = CMD_RESET;
        bus.tx_valid = 1'b1;
        xfer(CMD_RESET, 1'b1, 1);
        xfer(CMD_RESET, 1'b1, 2);
        repeat (5) @(negedge clk);
        chk("accepts", acc_cnt - a0, 2);

        for (int i = 0; i < 6; i++) begin
            rb   = 8'($urandom_range(0, 255));
            rack = ($urandom_range(0, 3) != 0);
            xfer(rb, rack, 0);
        end

        repeat (5) @(negedge clk);
        chk("total_done", done_cnt, exp_done);
        chk("total_err", err_cnt, exp_err);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
